// File: rtl/vga_pkg.sv
// Shared types, default 640x480 timing constants and helpers for the VGA scan-out slice.
// No logic state; latency and backpressure do not apply.
package vga_pkg;

  typedef enum logic [1:0] {
    SCALE_1X = 2'd0,
    SCALE_2X = 2'd1,
    SCALE_4X = 2'd2
  } scale_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // The unused encoding 3 falls back to 1x.
  function automatic scale_e decode_scale(input logic [1:0] raw);
    case (raw)
      2'd1:    return SCALE_2X;
      2'd2:    return SCALE_4X;
      default: return SCALE_1X;
    endcase
  endfunction

  // Repeats the low `width` bits of value MSB-first across a 16-bit result;
  // callers keep the top bits they need.
  function automatic logic [15:0] expand_field(input logic [7:0] value, input int width);
    logic [15:0] res;
    logic [2:0]  idx;
    res = '0;
    if (width > 0) begin
      for (int i = 0; i < 16; i++) begin
        idx = 3'(width - 1 - (i % width));
        res[4'(15 - i)] = value[idx];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical counters with active and sync decode; frame_start and vblank are registered.
// Decode is combinational from the counters; free-running, no backpressure.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   HW       = 10,
  parameter int   VW       = 10
) (
  input  logic          vga_clk,
  input  logic          wb_rst_i,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic          active,
  output logic          hs,
  output logic          vs,
  output logic          frame_start,
  output logic          vblank
);

  localparam logic [HW-1:0] H_ACT_L  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST   = HW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  always_ff @(posedge vga_clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      hcnt        <= '0;
      vcnt        <= '0;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
    end else begin
      frame_start <= (hcnt == '0) && (vcnt == '0);
      vblank      <= (vcnt >= V_ACT_L);
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  always_comb begin
    active = (hcnt < H_ACT_L) && (vcnt < V_ACT_L);
    hs     = ((hcnt >= HS_BEG) && (hcnt < HS_END)) ? HS_POL : ~HS_POL;
    vs     = ((vcnt >= VS_BEG) && (vcnt < VS_END)) ? VS_POL : ~VS_POL;
  end

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out: timing, upscaled framebuffer addressing and pixel/sync alignment; optional palette via VGA_PALETTE_EN.
// Address leads pins by RD_LAT+1 cycles (RD_LAT+2 with palette); free-running, no backpressure.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   PIX_W    = 8,
  parameter int   ADDR_W   = 19,
  parameter int   RD_LAT   = 1,
  parameter int   COLOR_W  = 4
) (
  input  logic                 vga_clk,
  input  logic                 wb_rst_i,
  input  logic                 enable_i,
  input  logic [1:0]           scale_i,
  input  logic [ADDR_W-1:0]    base_addr_i,
  output logic                 fb_en_o,
  output logic [ADDR_W-1:0]    fb_addr_o,
  input  logic [PIX_W-1:0]     fb_dat_i,
  output logic [COLOR_W-1:0]   vga_r,
  output logic [COLOR_W-1:0]   vga_g,
  output logic [COLOR_W-1:0]   vga_b,
  output logic                 vga_hs,
  output logic                 vga_vs,
  output logic                 frame_start_o,
  output logic                 vblank_o
`ifdef VGA_PALETTE_EN
  ,
  input  logic                 pal_we_i,
  input  logic [7:0]           pal_idx_i,
  input  logic [3*COLOR_W-1:0] pal_dat_i
`endif
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT + 1);
  localparam int VW    = $clog2(V_TOT + 1);
`ifdef VGA_PALETTE_EN
  localparam int PIPE  = RD_LAT + 2;
`else
  localparam int PIPE  = RD_LAT + 1;
`endif
  localparam logic [HW-1:0] H_END_ACT = HW'(H_ACTIVE - 1);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          active, hs, vs;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .HW(HW), .VW(VW)
  ) u_timing (
    .vga_clk     (vga_clk),
    .wb_rst_i    (wb_rst_i),
    .hcnt        (hcnt),
    .vcnt        (vcnt),
    .active      (active),
    .hs          (hs),
    .vs          (vs),
    .frame_start (frame_start_o),
    .vblank      (vblank_o)
  );

  logic              sh_en;
  scale_e            sh_scale;
  logic [ADDR_W-1:0] sh_base;
  logic [ADDR_W-1:0] line_ptr, pix_ptr;

  logic              first, en_e, step_pix, step_line, line_end;
  scale_e            sc_e;
  logic [1:0]        shift, mask;
  logic [HW-1:0]     h_nxt;
  logic [VW-1:0]     v_nxt;
  logic [ADDR_W-1:0] base_e, line_w, line_cur, pix_cur, line_nxt;

  // The (0,0) cycle reads the inputs directly so pixel (0,0) already uses the new frame's settings.
  always_comb begin
    first     = (hcnt == '0) && (vcnt == '0);
    en_e      = first ? enable_i : sh_en;
    sc_e      = first ? decode_scale(scale_i) : sh_scale;
    base_e    = first ? base_addr_i : sh_base;
    case (sc_e)
      SCALE_2X: begin shift = 2'd1; mask = 2'b01; end
      SCALE_4X: begin shift = 2'd2; mask = 2'b11; end
      default:  begin shift = 2'd0; mask = 2'b00; end
    endcase
    line_w    = ADDR_W'(H_ACTIVE) >> shift;
    h_nxt     = hcnt + 1'b1;
    v_nxt     = vcnt + 1'b1;
    line_end  = (hcnt == H_END_ACT);
    line_cur  = first ? base_e : line_ptr;
    pix_cur   = first ? base_e : pix_ptr;
    step_pix  = ((h_nxt[1:0] & mask) == 2'b00);
    step_line = ((v_nxt[1:0] & mask) == 2'b00);
    line_nxt  = line_cur + (step_line ? line_w : '0);
  end

  always_ff @(posedge vga_clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sh_en     <= 1'b0;
      sh_scale  <= SCALE_1X;
      sh_base   <= '0;
      line_ptr  <= '0;
      pix_ptr   <= '0;
      fb_en_o   <= 1'b0;
      fb_addr_o <= '0;
    end else begin
      if (first) begin
        sh_en    <= enable_i;
        sh_scale <= decode_scale(scale_i);
        sh_base  <= base_addr_i;
      end
      fb_en_o <= active && en_e;
      if (active && en_e) fb_addr_o <= pix_cur;
      if (active) begin
        if (line_end) begin
          line_ptr <= line_nxt;
          pix_ptr  <= line_nxt;
        end else begin
          line_ptr <= line_cur;
          pix_ptr  <= pix_cur + {{(ADDR_W-1){1'b0}}, step_pix};
        end
      end
    end
  end

  logic [COLOR_W-1:0] pix_r, pix_g, pix_b;

`ifdef VGA_PALETTE_EN
  logic [3*COLOR_W-1:0] pal_mem [256];
  logic [3*COLOR_W-1:0] pal_q;

  // Read-before-write: a same-index write and read returns the old entry.
  always_ff @(posedge vga_clk) begin
    if (pal_we_i) pal_mem[pal_idx_i] <= pal_dat_i;
    pal_q <= pal_mem[fb_dat_i[7:0]];
  end

  assign pix_r = pal_q[3*COLOR_W-1 -: COLOR_W];
  assign pix_g = pal_q[2*COLOR_W-1 -: COLOR_W];
  assign pix_b = pal_q[COLOR_W-1 -: COLOR_W];
`else
  logic [15:0] r_x, g_x, b_x;

  always_comb begin
    r_x = expand_field(8'(fb_dat_i[7:5]), 3);
    g_x = expand_field(8'(fb_dat_i[4:2]), 3);
    b_x = expand_field(8'(fb_dat_i[1:0]), 2);
  end

  assign pix_r = COLOR_W'(r_x >> (16 - COLOR_W));
  assign pix_g = COLOR_W'(g_x >> (16 - COLOR_W));
  assign pix_b = COLOR_W'(b_x >> (16 - COLOR_W));
`endif

  logic [PIPE-1:0] act_d, hs_d, vs_d;

  // Side-band delay so sync, blanking and colour leave on the same edge.
  always_ff @(posedge vga_clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      act_d  <= '0;
      hs_d   <= {PIPE{~HS_POL}};
      vs_d   <= {PIPE{~VS_POL}};
      vga_hs <= ~HS_POL;
      vga_vs <= ~VS_POL;
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
    end else begin
      act_d  <= {act_d[PIPE-2:0], active && en_e};
      hs_d   <= {hs_d[PIPE-2:0], hs};
      vs_d   <= {vs_d[PIPE-2:0], vs};
      vga_hs <= hs_d[PIPE-1];
      vga_vs <= vs_d[PIPE-1];
      if (act_d[PIPE-1]) begin
        vga_r <= pix_r;
        vga_g <= pix_g;
        vga_b <= pix_b;
      end else begin
        vga_r <= '0;
        vga_g <= '0;
        vga_b <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout on a reduced 16x10 raster with RD_LAT=2 and a modelled framebuffer.
module tb_vga_scanout;

  localparam int H_ACTIVE = 8, H_FP = 2, H_SYNC = 3, H_BP = 3;
  localparam int V_ACTIVE = 6, V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int H_TOT = 16, V_TOT = 10, F_TOT = H_TOT * V_TOT;
  localparam int RD_LAT = 2, ADDR_W = 19, COLOR_W = 4, PIX_W = 8;
  localparam int PIN_LAT = RD_LAT + 1;

  logic vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic                 wb_rst_i;
  logic                 enable_i;
  logic [1:0]           scale_i;
  logic [ADDR_W-1:0]    base_addr_i;
  logic                 fb_en_o;
  logic [ADDR_W-1:0]    fb_addr_o;
  logic [PIX_W-1:0]     fb_dat_i;
  logic [COLOR_W-1:0]   vga_r, vga_g, vga_b;
  logic                 vga_hs, vga_vs, frame_start_o, vblank_o;
`ifdef VGA_PALETTE_EN
  logic                 pal_we_i = 1'b0;
  logic [7:0]           pal_idx_i = '0;
  logic [3*COLOR_W-1:0] pal_dat_i = '0;
`endif

  vga_scanout #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIX_W(PIX_W), .ADDR_W(ADDR_W),
    .RD_LAT(RD_LAT), .COLOR_W(COLOR_W)
  ) dut (
    .vga_clk(vga_clk), .wb_rst_i(wb_rst_i), .enable_i(enable_i), .scale_i(scale_i),
    .base_addr_i(base_addr_i), .fb_en_o(fb_en_o), .fb_addr_o(fb_addr_o), .fb_dat_i(fb_dat_i),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .frame_start_o(frame_start_o), .vblank_o(vblank_o)
`ifdef VGA_PALETTE_EN
    , .pal_we_i(pal_we_i), .pal_idx_i(pal_idx_i), .pal_dat_i(pal_dat_i)
`endif
  );

  int checks = 0;
  int fails  = 0;

  typedef struct {
    int          due;
    logic [11:0] rgb;
  } pix_t;

  logic [ADDR_W-1:0] exp_q[$];
  pix_t              pix_q[$];

  // Per-frame configurations: base, scale, enable.
  logic [ADDR_W-1:0] cfg_base  [7] = '{19'h0, 19'h100, 19'h0, 19'h40, 19'h7FFFF, 19'h55, 19'h20};
  logic [1:0]        cfg_scale [7] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
  logic              cfg_en    [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  function automatic logic [7:0] ram_f(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ 8'hE0;
  endfunction

  // RGB332 with each field's MSBs repeated to 4 bits.
  function automatic logic [11:0] unpack(input logic [7:0] p);
    return {p[7:5], p[7], p[4:2], p[4], p[1:0], p[1:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input int n);
    int s;
    logic [ADDR_W-1:0] a;
    s = (cfg_scale[n] == 2'd1) ? 1 : (cfg_scale[n] == 2'd2) ? 2 : 0;
    if (cfg_en[n]) begin
      for (int v = 0; v < V_ACTIVE; v++)
        for (int h = 0; h < H_ACTIVE; h++) begin
          a = cfg_base[n] + ADDR_W'((v >> s) * (H_ACTIVE >> s) + (h >> s));
          exp_q.push_back(a);
        end
    end
  endtask

  task automatic apply_cfg(input int n);
    base_addr_i = cfg_base[n];
    scale_i     = cfg_scale[n];
    enable_i    = cfg_en[n];
  endtask

  task automatic wait_frame_start();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * F_TOT && !seen; i++) begin
      @(negedge vga_clk);
      seen = frame_start_o;
    end
    if (!seen) check("frame_start_wait", frame_start_o, 1);
  endtask

  task automatic check_reset_outputs();
    check("rst_r", vga_r, 0);
    check("rst_g", vga_g, 0);
    check("rst_b", vga_b, 0);
    check("rst_hs", vga_hs, 1);
    check("rst_vs", vga_vs, 1);
    check("rst_fb_en", fb_en_o, 0);
    check("rst_fb_addr", fb_addr_o, 0);
    check("rst_frame_start", frame_start_o, 0);
    check("rst_vblank", vblank_o, 0);
  endtask

  // Framebuffer model: data appears RD_LAT cycles after its address.
  initial begin
    logic [ADDR_W-1:0] hist [RD_LAT];
    for (int i = 0; i < RD_LAT; i++) hist[i] = '0;
    fb_dat_i = '0;
    forever begin
      @(negedge vga_clk);
      fb_dat_i = ram_f(hist[RD_LAT-1]);
      for (int i = RD_LAT - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = fb_addr_o;
    end
  end

  // Monitor: k counts clock edges since reset release; after edge k the
  // fetch stage shows raster position k-1 and the pins show k-1-PIN_LAT.
  initial begin
    int k, q, p, ph, pv;
    logic [ADDR_W-1:0] last_addr, e;
    logic [11:0] exp_rgb;
    pix_t pe;
    k = 0;
    last_addr = '0;
    forever begin
      @(posedge vga_clk);
      #2;
      if (wb_rst_i) begin
        k = 0;
        last_addr = '0;
        pix_q.delete();
      end else begin
        k++;
        q = (k - 1) % F_TOT;
        check("frame_start", frame_start_o, (q == 0));
        check("vblank", vblank_o, ((q / H_TOT) >= V_ACTIVE));
        if (fb_en_o) begin
          check("fetch_in_active", ((q % H_TOT) < H_ACTIVE) && ((q / H_TOT) < V_ACTIVE), 1);
          if (exp_q.size() == 0) begin
            check("fb_en_unexpected", fb_en_o, 0);
          end else begin
            e = exp_q.pop_front();
            check("fb_addr", fb_addr_o, e);
            last_addr = e;
            pe.due = k + PIN_LAT;
            pe.rgb = unpack(ram_f(e));
            pix_q.push_back(pe);
          end
        end else begin
          check("fb_addr_hold", fb_addr_o, last_addr);
        end
        p = k - 1 - PIN_LAT;
        if (p < 0) begin
          check("pin_hs_pre", vga_hs, 1);
          check("pin_vs_pre", vga_vs, 1);
        end else begin
          ph = (p % F_TOT) % H_TOT;
          pv = (p % F_TOT) / H_TOT;
          check("pin_hs", vga_hs, !(ph >= 10 && ph < 13));
          check("pin_vs", vga_vs, !(pv >= 7 && pv < 9));
        end
        exp_rgb = '0;
        if (pix_q.size() > 0 && pix_q[0].due == k) begin
          pe = pix_q.pop_front();
          exp_rgb = pe.rgb;
        end
        check("pin_rgb", {vga_r, vga_g, vga_b}, exp_rgb);
      end
    end
  end

  initial begin
    wb_rst_i = 1'b1;
    apply_cfg(0);
    repeat (3) @(negedge vga_clk);
    check_reset_outputs();
    push_frame(0);
    @(negedge vga_clk);
    wb_rst_i = 1'b0;

    // New settings land right after each frame start, so they are mid-frame for the current one.
    for (int n = 1; n < 7; n++) begin
      wait_frame_start();
      apply_cfg(n);
      push_frame(n);
    end
    wait_frame_start();

    repeat (37) @(negedge vga_clk);
    wb_rst_i = 1'b1;
    #1;
    check_reset_outputs();
    exp_q.delete();
    base_addr_i = 19'h300;
    scale_i     = 2'd0;
    enable_i    = 1'b1;
    push_frame_base300();
    repeat (2) @(negedge vga_clk);
    wb_rst_i = 1'b0;

    wait_frame_start();
    enable_i = 1'b0;
    wait_frame_start();
    repeat (8) @(negedge vga_clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("pix_q_drained", pix_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  task automatic push_frame_base300();
    for (int v = 0; v < V_ACTIVE; v++)
      for (int h = 0; h < H_ACTIVE; h++)
        exp_q.push_back(19'h300 + ADDR_W'(v * H_ACTIVE + h));
  endtask

endmodule
